// File: rtl/key_eeprom_counter.sv
// Persistent 8-bit key-press counter kept in an I2C EEPROM via a byte-level master.
// Latency: key_press in IDLE at edge N raises i2c_req from edge N+1; value updates on the edge that samples a good i2c_done.
// Backpressure: i2c_req is held until i2c_ack; presses arriving while busy collapse into one pending increment.
//
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   key_press                - one-cycle debounced press pulse
//   i2c_req/rw/addr/wdata    - request to the byte master (rw: 1 = write)
//   i2c_ack/done/nack/rdata  - master accept pulse, completion pulse, NACK qualifier, read byte
//   value, value_valid       - current counter and "loaded/stored in EEPROM" flag
//   busy, err                - activity indicator and sticky error flag
module key_eeprom_counter #(
  parameter int         FREQ      = 50,
  parameter int         BOOT_MS   = 10,
  parameter int         TWR_MS    = 5,
  parameter logic [7:0] MEM_ADDR  = 8'h00,
  parameter int         MAX_RETRY = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_press,
  output logic       i2c_req,
  output logic       i2c_rw,
  output logic [7:0] i2c_addr,
  output logic [7:0] i2c_wdata,
  input  logic       i2c_ack,
  input  logic       i2c_done,
  input  logic       i2c_nack,
  input  logic [7:0] i2c_rdata,
  output logic [7:0] value,
  output logic       value_valid,
  output logic       busy,
  output logic       err
);

  typedef enum logic [2:0] {
    BOOT_WAIT, RD_REQ, RD_WAIT, IDLE, WR_REQ, WR_WAIT, TWR_WAIT, ERROR
  } state_t;

  localparam logic [31:0] BOOT_LAST = 32'(BOOT_MS * 1000 * FREQ - 1);
  localparam logic [31:0] TWR_LAST  = 32'(TWR_MS * 1000 * FREQ - 1);
  localparam logic [7:0]  RETRY_LIM = 8'(MAX_RETRY);

  state_t      r_state, w_state_nxt;
  logic [31:0] r_timer, w_timer_nxt;
  logic [7:0]  r_value, w_value_nxt;
  logic        r_valid, w_valid_nxt;
  logic [7:0]  r_wdata, w_wdata_nxt;
  logic        r_pending, w_pending_nxt;
  logic [7:0]  r_retry, w_retry_nxt;

  logic w_is_req, w_is_wait, w_is_wr, w_xfer_done;

  assign w_is_req  = (r_state == RD_REQ)  || (r_state == WR_REQ);
  assign w_is_wait = (r_state == RD_WAIT) || (r_state == WR_WAIT);
  assign w_is_wr   = (r_state == WR_REQ)  || (r_state == WR_WAIT);
  // A done arriving together with the ack is taken as ack-then-done.
  assign w_xfer_done = i2c_done && (w_is_wait || (w_is_req && i2c_ack));

  // Request outputs decode straight from state so reset drops i2c_req asynchronously.
  assign i2c_req     = w_is_req;
  assign i2c_rw      = (r_state == WR_REQ);
  assign i2c_addr    = MEM_ADDR;
  assign i2c_wdata   = r_wdata;
  assign value       = r_value;
  assign value_valid = r_valid;
  assign busy        = (r_state != IDLE) && (r_state != ERROR);
  assign err         = (r_state == ERROR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= BOOT_WAIT;
      r_timer   <= 32'd0;
      r_value   <= 8'h00;
      r_valid   <= 1'b0;
      r_wdata   <= 8'h00;
      r_pending <= 1'b0;
      r_retry   <= 8'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_timer   <= w_timer_nxt;
      r_value   <= w_value_nxt;
      r_valid   <= w_valid_nxt;
      r_wdata   <= w_wdata_nxt;
      r_pending <= w_pending_nxt;
      r_retry   <= w_retry_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_value_nxt   = r_value;
    w_valid_nxt   = r_valid;
    w_wdata_nxt   = r_wdata;
    w_pending_nxt = r_pending;
    w_retry_nxt   = r_retry;

    // One-deep press memory; IDLE consumes presses directly, ERROR ignores them.
    if (key_press && busy) begin
      w_pending_nxt = 1'b1;
    end

    case (r_state)
      BOOT_WAIT: begin
        if (r_timer == BOOT_LAST) w_state_nxt = RD_REQ;
      end
      RD_REQ, RD_WAIT, WR_REQ, WR_WAIT: begin
        if (w_xfer_done) begin
          if (!i2c_nack) begin
            w_value_nxt = w_is_wr ? r_wdata : i2c_rdata;
            w_valid_nxt = 1'b1;
            w_retry_nxt = 8'd0;
            w_state_nxt = w_is_wr ? TWR_WAIT : IDLE;
          end else if (r_retry < RETRY_LIM) begin
            // Retry reissues the same direction; r_wdata is untouched.
            w_retry_nxt = r_retry + 8'd1;
            w_state_nxt = w_is_wr ? WR_REQ : RD_REQ;
          end else begin
            w_state_nxt = ERROR;
          end
        end else if (w_is_req && i2c_ack) begin
          w_state_nxt = w_is_wr ? WR_WAIT : RD_WAIT;
        end
      end
      IDLE: begin
        // A press in the same cycle as a pending one merges into one increment.
        if (key_press || r_pending) begin
          w_wdata_nxt   = r_value + 8'd1;
          w_pending_nxt = 1'b0;
          w_state_nxt   = WR_REQ;
        end
      end
      TWR_WAIT: begin
        if (r_timer == TWR_LAST) w_state_nxt = IDLE;
      end
      ERROR: begin
        w_state_nxt = ERROR;
      end
      default: begin
        w_state_nxt = ERROR;
      end
    endcase

    w_timer_nxt = (w_state_nxt != r_state) ? 32'd0 : r_timer + 32'd1;
  end

endmodule

// File: tb/tb_key_eeprom_counter.sv
module tb_key_eeprom_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_press;
  logic       i2c_req, i2c_rw;
  logic [7:0] i2c_addr, i2c_wdata;
  logic       i2c_ack, i2c_done, i2c_nack;
  logic [7:0] i2c_rdata;
  logic [7:0] value;
  logic       value_valid, busy, err;

  key_eeprom_counter #(
    .FREQ(1), .BOOT_MS(1), .TWR_MS(1), .MEM_ADDR(8'h00), .MAX_RETRY(3)
  ) dut (
    .clk(clk), .rst(rst), .key_press(key_press),
    .i2c_req(i2c_req), .i2c_rw(i2c_rw), .i2c_addr(i2c_addr), .i2c_wdata(i2c_wdata),
    .i2c_ack(i2c_ack), .i2c_done(i2c_done), .i2c_nack(i2c_nack), .i2c_rdata(i2c_rdata),
    .value(value), .value_valid(value_valid), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rw;
    logic [7:0] wdata;
  } req_exp_t;

  req_exp_t   req_q[$];
  logic [7:0] val_q[$];
  bit         nack_q[$];
  logic [7:0] mem_byte = 8'h00;
  int         n_vec = 0;
  int         n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // EEPROM master model: ack 3 cycles after req, done 20 cycles after ack.
  logic m_abort;
  initial begin
    i2c_ack = 1'b0; i2c_done = 1'b0; i2c_nack = 1'b0; i2c_rdata = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (i2c_req && !rst) begin
        m_abort = 1'b0;
        for (int k = 0; k < 2; k++) begin
          @(posedge clk); #1;
          if (rst) m_abort = 1'b1;
        end
        if (!m_abort) begin
          i2c_ack = 1'b1;
          @(posedge clk); #1;
          i2c_ack = 1'b0;
          if (rst) m_abort = 1'b1;
          for (int k = 0; k < 19; k++) begin
            @(posedge clk); #1;
            if (rst) m_abort = 1'b1;
          end
          if (!m_abort) begin
            i2c_done  = 1'b1;
            i2c_rdata = mem_byte;
            i2c_nack  = 1'b0;
            if (nack_q.size() > 0) i2c_nack = nack_q.pop_front();
            @(posedge clk); #1;
            i2c_done = 1'b0;
            i2c_nack = 1'b0;
          end
        end
      end
    end
  end

  // Scoreboard monitor: accepted requests and value changes are matched against queues.
  req_exp_t   mon_e;
  logic [7:0] prev_value = 8'h00;
  logic [7:0] mon_v;
  always @(negedge clk) begin
    if (rst) begin
      prev_value = 8'h00;
    end else begin
      if (i2c_req && i2c_ack) begin
        if (req_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL req_unexpected: got rw=%0b wdata=%0h, expected no request", i2c_rw, i2c_wdata);
        end else begin
          mon_e = req_q.pop_front();
          check("req_rw", {31'd0, i2c_rw}, {31'd0, mon_e.rw});
          check("req_addr", {24'd0, i2c_addr}, 32'h00);
          if (mon_e.rw) check("req_wdata", {24'd0, i2c_wdata}, {24'd0, mon_e.wdata});
        end
      end
      if (value !== prev_value) begin
        if (val_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL value_unexpected: got %0h, expected %0h unchanged", value, prev_value);
        end else begin
          mon_v = val_q.pop_front();
          check("value_update", {24'd0, value}, {24'd0, mon_v});
        end
        prev_value = value;
      end
    end
  end

  task automatic push_req(input logic rw, input logic [7:0] wd);
    req_exp_t e;
    e.rw = rw; e.wdata = wd;
    req_q.push_back(e);
  endtask

  task automatic press();
    key_press = 1'b1;
    @(posedge clk); #1;
    key_press = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max);
    int c = 0;
    while (busy && c < max) begin @(posedge clk); #1; c++; end
    check(name, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_value(input string name, input logic [7:0] v, input int max);
    int c = 0;
    while (value !== v && c < max) begin @(posedge clk); #1; c++; end
    check(name, {24'd0, value}, {24'd0, v});
  endtask

  // Release reset and verify the power-up read returning rd.
  task automatic boot_seq(input logic [7:0] rd);
    mem_byte = rd;
    push_req(1'b0, 8'h00);
    val_q.push_back(rd);
    @(negedge clk); rst = 1'b0;
    repeat (999) @(posedge clk);
    #1 check("boot_req_early", {31'd0, i2c_req}, 32'd0);
    @(posedge clk);
    #1 check("boot_req_edge", {31'd0, i2c_req}, 32'd1);
    check("boot_rw", {31'd0, i2c_rw}, 32'd0);
    wait_idle("boot_idle", 200);
    check("boot_value", {24'd0, value}, {24'd0, rd});
    check("boot_valid", {31'd0, value_valid}, 32'd1);
  endtask

  initial begin
    int cnt;
    rst = 1'b1; key_press = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_value", {24'd0, value}, 32'd0);
    check("rst_valid", {31'd0, value_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd1);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_req", {31'd0, i2c_req}, 32'd0);
    check("rst_wdata", {24'd0, i2c_wdata}, 32'd0);

    boot_seq(8'h2A);

    // Single press with write-cycle timing.
    push_req(1'b1, 8'h2B); val_q.push_back(8'h2B);
    press();
    check("press_req", {31'd0, i2c_req}, 32'd1);
    check("press_rw", {31'd0, i2c_rw}, 32'd1);
    check("press_wdata", {24'd0, i2c_wdata}, 32'h2B);
    wait_value("press_value", 8'h2B, 200);
    cnt = 0;
    while (busy && cnt < 3000) begin @(posedge clk); #1; cnt++; end
    check("twr_cycles", cnt, 32'd1000);

    // Presses while busy collapse into one follow-up write.
    push_req(1'b1, 8'h2C); val_q.push_back(8'h2C);
    push_req(1'b1, 8'h2D); val_q.push_back(8'h2D);
    press();
    repeat (8) @(posedge clk);
    #1 press();
    wait_value("busy_first_value", 8'h2C, 200);
    repeat (5) @(posedge clk);
    #1 press();
    repeat (5) @(posedge clk);
    #1 press();
    cnt = 0;
    while (busy && cnt < 3000) begin @(posedge clk); #1; cnt++; end
    check("pending_idle_seen", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    check("pending_req", {31'd0, i2c_req}, 32'd1);
    check("pending_wdata", {24'd0, i2c_wdata}, 32'h2D);
    wait_idle("pending_done", 3000);
    repeat (50) @(posedge clk);
    #1 check("no_extra_write", {31'd0, i2c_req}, 32'd0);
    check("pending_value", {24'd0, value}, 32'h2D);

    // Two NACKs then success: three requests, one value update.
    nack_q.push_back(1'b1); nack_q.push_back(1'b1);
    push_req(1'b1, 8'h2E); push_req(1'b1, 8'h2E); push_req(1'b1, 8'h2E);
    val_q.push_back(8'h2E);
    press();
    wait_idle("retry_done", 3000);
    check("retry_err", {31'd0, err}, 32'd0);
    check("retry_value", {24'd0, value}, 32'h2E);

    // Asynchronous reset while a write request is outstanding.
    press();
    check("rstmid_req_before", {31'd0, i2c_req}, 32'd1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("rstmid_req", {31'd0, i2c_req}, 32'd0);
    check("rstmid_value", {24'd0, value}, 32'd0);
    check("rstmid_valid", {31'd0, value_valid}, 32'd0);
    check("rstmid_busy", {31'd0, busy}, 32'd1);
    repeat (3) @(posedge clk);
    boot_seq(8'hFF);

    // Wrap from FF to 00.
    push_req(1'b1, 8'h00); val_q.push_back(8'h00);
    press();
    check("wrap_wdata", {24'd0, i2c_wdata}, 32'h00);
    wait_idle("wrap_done", 3000);
    check("wrap_value", {24'd0, value}, 32'h00);

    // Four NACKs exhaust retries and lock into error.
    for (int i = 0; i < 4; i++) begin
      nack_q.push_back(1'b1);
      push_req(1'b1, 8'h01);
    end
    press();
    wait_idle("error_reached", 3000);
    check("error_err", {31'd0, err}, 32'd1);
    check("error_value", {24'd0, value}, 32'h00);
    press();
    repeat (50) @(posedge clk);
    #1 check("error_no_req", {31'd0, i2c_req}, 32'd0);
    check("error_busy", {31'd0, busy}, 32'd0);
    check("error_sticky", {31'd0, err}, 32'd1);

    check("req_q_drained", req_q.size(), 32'd0);
    check("val_q_drained", val_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
